// File: rtl/atm_db_arbiter.sv
// -----------------------------------------------------------------------------
// atm_db_arbiter
// Round-robin arbiter and read-modify-write sequencer sharing one single-port
// account-balance memory between NUM_PORTS ATM front-end controllers.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   req             per-port request (level)
//   card_in         port i card at [i*card_width +: card_width]
//   op_in           port i op at [i*2 +: 2]: 00 withdraw, 01 deposit,
//                   10 inquiry, 11 invalid
//   value_in        port i value at [i*balance_width +: balance_width]
//   grant           one-hot owner of the current transaction, 0 when idle
//   done            one-cycle pulse to the owner at transaction end
//   error           valid with done: operation rejected
//   result_balance  valid with done: balance after the operation
//   busy            high whenever the sequencer is not idle
//   mem_addr        balance memory address
//   mem_rd_data     synchronous read data, valid one cycle after mem_addr
//   mem_wr_en       one-cycle write strobe
//   mem_wr_data     write data
// -----------------------------------------------------------------------------
module atm_db_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int card_width    = 3,
    parameter int balance_width = 20,
    parameter int users_num     = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS-1:0]               req,
    input  logic [NUM_PORTS*card_width-1:0]    card_in,
    input  logic [NUM_PORTS*2-1:0]             op_in,
    input  logic [NUM_PORTS*balance_width-1:0] value_in,
    output logic [NUM_PORTS-1:0]               grant,
    output logic [NUM_PORTS-1:0]               done,
    output logic                               error,
    output logic [balance_width-1:0]           result_balance,
    output logic                               busy,
    output logic [card_width-1:0]              mem_addr,
    input  logic [balance_width-1:0]           mem_rd_data,
    output logic                               mem_wr_en,
    output logic [balance_width-1:0]           mem_wr_data
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [card_width:0] USERS = (card_width+1)'(users_num);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_t;
    typedef enum logic [1:0] {OP_WITHDRAW, OP_DEPOSIT, OP_INQUIRY, OP_INVALID} op_t;

    state_t                   r_state;
    logic [PW-1:0]            r_ptr;
    logic [PW-1:0]            r_owner;
    logic [card_width-1:0]    r_card;
    op_t                      r_op;
    logic [balance_width-1:0] r_value;
    logic [balance_width-1:0] r_bal;
    logic                     r_err;
    logic [NUM_PORTS-1:0]     r_grant;
    logic [NUM_PORTS-1:0]     r_done;
    logic                     r_error;
    logic [balance_width-1:0] r_result;
    logic [card_width-1:0]    r_mem_addr;
    logic                     r_wr_en;
    logic [balance_width-1:0] r_wr_data;

    logic [card_width-1:0]    w_cards  [NUM_PORTS];
    logic [1:0]               w_ops    [NUM_PORTS];
    logic [balance_width-1:0] w_values [NUM_PORTS];
    logic                     w_any;
    logic [PW-1:0]            w_winner;
    logic [PW:0]              w_idx;
    logic                     w_req_ok;
    logic [balance_width:0]   w_sum;
    logic [balance_width-1:0] w_new_bal;
    logic                     w_err;
    logic                     w_wr;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_cards[g]  = card_in[g*card_width +: card_width];
        assign w_ops[g]    = op_in[g*2 +: 2];
        assign w_values[g] = value_in[g*balance_width +: balance_width];
    end

    // Scan ports starting at the pointer; the index wraps without a modulo
    // so NUM_PORTS need not be a power of two.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NUM_PORTS))
                w_idx = w_idx - (PW+1)'(NUM_PORTS);
            if (!w_any && req[w_idx[PW-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_idx[PW-1:0];
            end
        end
    end

    assign w_req_ok = ({1'b0, r_card} < USERS) && (r_op != OP_INVALID);

    // Balance update from the read data; the deposit sum carries one extra
    // bit so overflow is detected rather than wrapped.
    always_comb begin
        w_sum     = {1'b0, mem_rd_data} + {1'b0, r_value};
        w_new_bal = mem_rd_data;
        w_err     = 1'b0;
        w_wr      = 1'b0;
        case (r_op)
            OP_WITHDRAW: begin
                if (r_value > mem_rd_data) begin
                    w_err = 1'b1;
                end else begin
                    w_new_bal = mem_rd_data - r_value;
                    w_wr      = 1'b1;
                end
            end
            OP_DEPOSIT: begin
                if (w_sum[balance_width]) begin
                    w_err = 1'b1;
                end else begin
                    w_new_bal = w_sum[balance_width-1:0];
                    w_wr      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_card     <= '0;
            r_op       <= OP_WITHDRAW;
            r_value    <= '0;
            r_bal      <= '0;
            r_err      <= 1'b0;
            r_grant    <= '0;
            r_done     <= '0;
            r_error    <= 1'b0;
            r_result   <= '0;
            r_mem_addr <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_winner;
                        r_card  <= w_cards[w_winner];
                        r_op    <= op_t'(w_ops[w_winner]);
                        r_value <= w_values[w_winner];
                        r_grant <= NUM_PORTS'(1) << w_winner;
                        // Out-of-range cards never reach the memory bus.
                        if ({1'b0, w_cards[w_winner]} < USERS)
                            r_mem_addr <= w_cards[w_winner];
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_req_ok) begin
                        r_state <= S_EXEC;
                    end else begin
                        // No balance was read, so the reported balance is 0.
                        r_done   <= r_grant;
                        r_error  <= 1'b1;
                        r_result <= '0;
                        r_state  <= S_DONE;
                    end
                end
                S_EXEC: begin
                    r_bal   <= w_new_bal;
                    r_err   <= w_err;
                    r_wr_en <= w_wr;
                    if (w_wr)
                        r_wr_data <= w_new_bal;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_wr_en  <= 1'b0;
                    r_done   <= r_grant;
                    r_error  <= r_err;
                    r_result <= r_bal;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_ptr   <= (r_owner == PW'(NUM_PORTS-1)) ? '0 : r_owner + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant          = r_grant;
    assign done           = r_done;
    assign error          = r_error;
    assign result_balance = r_result;
    assign busy           = (r_state != S_IDLE);
    assign mem_addr       = r_mem_addr;
    assign mem_wr_en      = r_wr_en;
    assign mem_wr_data    = r_wr_data;

endmodule
